mcu_framebuffer_port: RTL and testbench
=======================================

// Module: mcu_framebuffer_port
// PURPOSE
// - Async MCU parallel-bus slave feeding the framebuffer write port; successor of the single-pixel MCU interface.
// - Adds: parametrised X/Y/data widths, FIFO_DEPTH-entry pixel write FIFO, X wrap with automatic Y advance, status readback.
// - Sits between the external MCU pins and the memory arbiter's write channel; one clock domain (clock), MCU strobes synchronised in.
// PARAMETERS
// - X_WIDTH      9    bits of X coordinate (address low field)
// - Y_WIDTH      8    bits of Y coordinate (address high field)
// - DATA_WIDTH   8    pixel width; also MCU bus width
// - X_LIMIT      320  first X value that wraps (row length)
// - FIFO_DEPTH   4    pixel FIFO entries, power of two, >= 2
// - SYNC_STAGES  2    synchroniser flops on MCU strobe, >= 2
// PORTS
// - clock               in   1                 system clock
// - reset               in   1                 synchronous, active-high
// - mpuChipSelect       in   1                 active-high select
// - mpuWriteEnable      in   1                 active-low write strobe
// - mpuOutputEnable     in   1                 active-low read strobe
// - mpuRegisterSelect   in   3                 register index
// - mpuDataBus          inout DATA_WIDTH       MCU data; driven only during reads
// - memoryAddress       out  X_WIDTH+Y_WIDTH   {Y, X} of pixel being written
// - memoryWriteData     out  DATA_WIDTH        pixel value
// - memoryWriteRequest  out  1                 held high until memoryWriteComplete
// - memoryWriteComplete in   1                 one-cycle ack from arbiter
// BEHAVIOUR
// - Registers: 0 X_LOW, 1 X_HIGH, 2 Y, 3 DATA, 4 X_INCREMENT, 5 CONTROL, 6 STATUS (RO), 7 reserved (reads 0, writes ignored).
// - Write strobe = mpuChipSelect & !mpuWriteEnable, passed through SYNC_STAGES flops; mpuRegisterSelect/mpuDataBus sampled every
//   cycle the synced strobe is high; commit on cycle the synced strobe falls (trailing edge), using last sampled values.
// - X_LOW/X_HIGH/Y load cursor fields; X_HIGH uses bits [X_WIDTH-9:0] (excess bits dropped).
// - DATA commit: push {cursor, data}; cursor X += X_INCREMENT. If new X >= X_LIMIT: CONTROL[0]=1 -> X -= X_LIMIT, Y += 1 (mod 2^Y_WIDTH);
//   CONTROL[0]=0 -> X truncated mod 2^X_WIDTH (legacy). Cursor advances even when push is dropped.
// - FIFO full at DATA commit: pixel dropped, STATUS.overflow sticky set. Writing CONTROL with bit1=1 clears overflow (bit1 not stored).
// - Drain: when memoryWriteRequest low and FIFO non-empty, pop head to memoryAddress/memoryWriteData and raise memoryWriteRequest
//   next cycle. Request and outputs held stable until memoryWriteComplete seen; request drops the following cycle; next pop
//   earliest one cycle after drop. Complete while request low ignored. Push and pop in the same cycle both take effect.
// - STATUS: bit0 fifoEmpty, bit1 fifoFull, bit2 overflow, bit3 busy (request high or FIFO non-empty), upper bits 0.
// - Read: mpuDataBus driven combinationally from registered values when mpuChipSelect & !mpuOutputEnable, else Z.
//   Readable: X_LOW, X_HIGH, Y, X_INCREMENT, CONTROL (bit0 only), STATUS. DATA reads 0.
// - Simultaneous read and write strobes: write takes effect, bus not driven.
// - Reset (any cycle, incl. mid-transfer): cursor 0, X_INCREMENT 1, CONTROL 0, overflow 0, FIFO emptied, sync flops 0,
//   memoryWriteRequest 0, memoryAddress 0, memoryWriteData 0; pending arbiter ack after reset ignored.
// - Latency: trailing strobe edge at MCU -> memoryWriteRequest high = SYNC_STAGES+3 cycles with empty FIFO.
// STRUCTURE
// - mcu_interface_pkg: register index enum, CONTROL/STATUS bit positions, reset constants.
// - Sub-module mcu_write_fifo (parametrised width/depth, push/pop/full/empty); rest (sync, decode, cursor, drain FSM IDLE/REQUEST) local.
// TESTING
// - Write X=5,Y=2,DATA=0xAA -> one request, memoryAddress={8'd2,9'd5}, data 0xAA; request held until ack, drops next cycle.
// - X_INCREMENT=1, wrap on, X=319,Y=10, DATA x2 -> addresses {10,319} then {11,0}.
// - Wrap off, X=511, X_INCREMENT=1, DATA x2 -> {Y,511} then {Y,0}, Y unchanged.
// - Stall ack, write 6 pixels with FIFO_DEPTH=4 -> 5 writes issued in order (1 in flight + 4 queued), STATUS=0x0E; CONTROL=0x02 clears bit2.
// - Assert reset while request high and FIFO holding 3 -> request low next cycle, STATUS reads 0x01, later ack produces no write.
// - Read STATUS/X_LOW with output enable low -> bus shows values; with enable high -> bus Z.

Source files
------------

// File: rtl/mcu_interface_pkg.sv
// Shared definitions for the MCU framebuffer port: register map, bit positions and reset constants.
package mcu_interface_pkg;

    typedef enum logic [2:0] {
        REG_X_LOW       = 3'd0,
        REG_X_HIGH      = 3'd1,
        REG_Y           = 3'd2,
        REG_DATA        = 3'd3,
        REG_X_INCREMENT = 3'd4,
        REG_CONTROL     = 3'd5,
        REG_STATUS      = 3'd6,
        REG_RESERVED    = 3'd7
    } registerIndex_t;

    typedef enum logic {
        DRAIN_IDLE,
        DRAIN_REQUEST
    } drainState_t;

    localparam int CONTROL_WRAP_BIT           = 0;
    localparam int CONTROL_CLEAR_OVERFLOW_BIT = 1;

    localparam int STATUS_EMPTY_BIT    = 0;
    localparam int STATUS_FULL_BIT     = 1;
    localparam int STATUS_OVERFLOW_BIT = 2;
    localparam int STATUS_BUSY_BIT     = 3;

    localparam int RESET_X_INCREMENT = 1;

endpackage

// File: rtl/mcu_write_fifo.sv
// Small synchronous FIFO holding {address, pixel} entries between the MCU side and the drain FSM.
module mcu_write_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] readPtr;
    logic [PTR_W-1:0] writePtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = storage[readPtr];

    always_ff @(posedge clock) begin
        if (doPush) begin
            storage[writePtr] <= pushData;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else begin
            if (doPush) begin
                writePtr <= writePtr + 1'b1;
            end
            if (doPop) begin
                readPtr <= readPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcu_framebuffer_port.sv
// MCU parallel-bus slave: synchronises the write strobe, decodes registers, advances the pixel cursor
// and drains queued pixels to the memory arbiter with a request/complete handshake.
module mcu_framebuffer_port
    import mcu_interface_pkg::*;
#(
    parameter int X_WIDTH     = 9,
    parameter int Y_WIDTH     = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int X_LIMIT     = 320,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       mpuChipSelect,
    input  logic                       mpuWriteEnable,
    input  logic                       mpuOutputEnable,
    input  logic [2:0]                 mpuRegisterSelect,
    inout  wire  [DATA_WIDTH-1:0]      mpuDataBus,
    output logic [X_WIDTH+Y_WIDTH-1:0] memoryAddress,
    output logic [DATA_WIDTH-1:0]      memoryWriteData,
    output logic                       memoryWriteRequest,
    input  logic                       memoryWriteComplete
);
    localparam int ADDR_W  = X_WIDTH + Y_WIDTH;
    localparam int ENTRY_W = ADDR_W + DATA_WIDTH;
    localparam int SUM_W   = ((X_WIDTH > DATA_WIDTH) ? X_WIDTH : DATA_WIDTH) + 1;

    logic [SYNC_STAGES-1:0] strobeSync;
    logic                   strobeSynced;
    logic                   strobeDelayed;
    logic                   commitPending;
    logic [2:0]             sampledRegister;
    logic [DATA_WIDTH-1:0]  sampledData;
    registerIndex_t         commitRegister;
    logic                   writeStrobe;
    logic                   readStrobe;

    logic [X_WIDTH-1:0]     cursorX;
    logic [Y_WIDTH-1:0]     cursorY;
    logic [DATA_WIDTH-1:0]  xIncrement;
    logic                   wrapEnable;
    logic                   overflow;
    logic [SUM_W-1:0]       xSum;
    logic [X_WIDTH-1:0]     nextX;
    logic [Y_WIDTH-1:0]     nextY;

    logic                   dataCommit;
    logic                   fifoPush;
    logic                   fifoPop;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic [ENTRY_W-1:0]     fifoHead;
    drainState_t            state;
    drainState_t            nextState;

    logic [DATA_WIDTH-1:0]  statusValue;
    logic [DATA_WIDTH-1:0]  readData;

    assign writeStrobe    = mpuChipSelect && !mpuWriteEnable;
    assign readStrobe     = mpuChipSelect && !mpuOutputEnable && !writeStrobe;
    assign strobeSynced   = strobeSync[SYNC_STAGES-1];
    assign commitRegister = registerIndex_t'(sampledRegister);
    assign dataCommit     = commitPending && (commitRegister == REG_DATA);
    assign fifoPush       = dataCommit && !fifoFull;

    // The commit fires one cycle after the synced strobe falls, using the last values seen while it was high.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobeSync      <= '0;
            strobeDelayed   <= 1'b0;
            commitPending   <= 1'b0;
            sampledRegister <= '0;
            sampledData     <= '0;
        end else begin
            strobeSync    <= {strobeSync[SYNC_STAGES-2:0], writeStrobe};
            strobeDelayed <= strobeSynced;
            commitPending <= strobeDelayed && !strobeSynced;
            if (strobeSynced) begin
                sampledRegister <= mpuRegisterSelect;
                sampledData     <= mpuDataBus;
            end
        end
    end

    always_comb begin
        xSum  = SUM_W'(cursorX) + SUM_W'(xIncrement);
        nextX = X_WIDTH'(xSum);
        nextY = cursorY;
        if (wrapEnable && (xSum >= SUM_W'(X_LIMIT))) begin
            nextX = X_WIDTH'(xSum - SUM_W'(X_LIMIT));
            nextY = cursorY + Y_WIDTH'(1);
        end
    end

    // Cursor advances on every DATA commit, even when the pixel itself is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            cursorX    <= '0;
            cursorY    <= '0;
            xIncrement <= DATA_WIDTH'(RESET_X_INCREMENT);
            wrapEnable <= 1'b0;
            overflow   <= 1'b0;
        end else if (commitPending) begin
            case (commitRegister)
                REG_X_LOW:       cursorX[7:0] <= sampledData[7:0];
                REG_X_HIGH:      cursorX[X_WIDTH-1:8] <= sampledData[X_WIDTH-9:0];
                REG_Y:           cursorY <= Y_WIDTH'(sampledData);
                REG_DATA: begin
                    cursorX <= nextX;
                    cursorY <= nextY;
                    if (fifoFull) begin
                        overflow <= 1'b1;
                    end
                end
                REG_X_INCREMENT: xIncrement <= sampledData;
                REG_CONTROL: begin
                    wrapEnable <= sampledData[CONTROL_WRAP_BIT];
                    if (sampledData[CONTROL_CLEAR_OVERFLOW_BIT]) begin
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    mcu_write_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) pixelFifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifoPush),
        .pushData({cursorY, cursorX, sampledData}),
        .pop     (fifoPop),
        .headData(fifoHead),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            DRAIN_IDLE:    if (!fifoEmpty) nextState = DRAIN_REQUEST;
            DRAIN_REQUEST: if (memoryWriteComplete) nextState = DRAIN_IDLE;
            default:       nextState = DRAIN_IDLE;
        endcase
    end

    always_comb begin
        memoryWriteRequest = (state == DRAIN_REQUEST);
        fifoPop            = (state == DRAIN_IDLE) && !fifoEmpty;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            memoryAddress   <= '0;
            memoryWriteData <= '0;
        end else if (fifoPop) begin
            {memoryAddress, memoryWriteData} <= fifoHead;
        end
    end

    always_comb begin
        statusValue                      = '0;
        statusValue[STATUS_EMPTY_BIT]    = fifoEmpty;
        statusValue[STATUS_FULL_BIT]     = fifoFull;
        statusValue[STATUS_OVERFLOW_BIT] = overflow;
        statusValue[STATUS_BUSY_BIT]     = memoryWriteRequest || !fifoEmpty;
    end

    always_comb begin
        readData = '0;
        case (registerIndex_t'(mpuRegisterSelect))
            REG_X_LOW:       readData = DATA_WIDTH'(cursorX[7:0]);
            REG_X_HIGH:      readData = DATA_WIDTH'(cursorX[X_WIDTH-1:8]);
            REG_Y:           readData = DATA_WIDTH'(cursorY);
            REG_X_INCREMENT: readData = xIncrement;
            REG_CONTROL:     readData[CONTROL_WRAP_BIT] = wrapEnable;
            REG_STATUS:      readData = statusValue;
            default:         readData = '0;
        endcase
    end

    assign mpuDataBus = readStrobe ? readData : 'z;

endmodule

// File: tb/tb_mcu_framebuffer_port.sv
// Directed bench for mcu_framebuffer_port: MCU register writes/reads plus a simple arbiter model.
module tb_mcu_framebuffer_port;
    localparam int X_WIDTH     = 9;
    localparam int Y_WIDTH     = 8;
    localparam int DATA_WIDTH  = 8;
    localparam int X_LIMIT     = 320;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = X_WIDTH + Y_WIDTH;

    localparam logic [2:0] R_X_LOW  = 3'd0;
    localparam logic [2:0] R_X_HIGH = 3'd1;
    localparam logic [2:0] R_Y      = 3'd2;
    localparam logic [2:0] R_DATA   = 3'd3;
    localparam logic [2:0] R_X_INC  = 3'd4;
    localparam logic [2:0] R_CTRL   = 3'd5;
    localparam logic [2:0] R_STATUS = 3'd6;
    localparam logic [2:0] R_RSVD   = 3'd7;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  mpuChipSelect;
    logic                  mpuWriteEnable;
    logic                  mpuOutputEnable;
    logic [2:0]            mpuRegisterSelect;
    wire  [DATA_WIDTH-1:0] mpuDataBus;
    logic [DATA_WIDTH-1:0] tbData;
    logic                  tbDriveEn;
    logic [ADDR_W-1:0]     memoryAddress;
    logic [DATA_WIDTH-1:0] memoryWriteData;
    logic                  memoryWriteRequest;
    logic                  memoryWriteComplete;
    logic                  ackAuto = 1'b0;
    logic                  ackManual;
    logic                  autoAckEnable;

    logic [ADDR_W-1:0]     capAddr [$];
    logic [DATA_WIDTH-1:0] capData [$];
    int                    checks = 0;
    int                    failures = 0;
    int                    base;

    assign mpuDataBus          = tbDriveEn ? tbData : 'z;
    assign memoryWriteComplete = ackAuto | ackManual;

    always #5 clock = ~clock;

    mcu_framebuffer_port #(
        .X_WIDTH    (X_WIDTH),
        .Y_WIDTH    (Y_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .X_LIMIT    (X_LIMIT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .mpuChipSelect      (mpuChipSelect),
        .mpuWriteEnable     (mpuWriteEnable),
        .mpuOutputEnable    (mpuOutputEnable),
        .mpuRegisterSelect  (mpuRegisterSelect),
        .mpuDataBus         (mpuDataBus),
        .memoryAddress      (memoryAddress),
        .memoryWriteData    (memoryWriteData),
        .memoryWriteRequest (memoryWriteRequest),
        .memoryWriteComplete(memoryWriteComplete)
    );

    // Arbiter model: log each request and acknowledge it for one cycle.
    always @(negedge clock) begin
        if (autoAckEnable && memoryWriteRequest && !ackAuto) begin
            capAddr.push_back(memoryAddress);
            capData.push_back(memoryWriteData);
            ackAuto = 1'b1;
        end else begin
            ackAuto = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Write cycle; data stays driven until the commit has used the sampled value.
    task automatic applyStimulus(input logic [2:0] regIndex, input logic [7:0] value);
        @(negedge clock);
        mpuRegisterSelect = regIndex;
        tbData            = value;
        tbDriveEn         = 1'b1;
        mpuChipSelect     = 1'b1;
        mpuWriteEnable    = 1'b0;
        repeat (3) @(negedge clock);
        mpuWriteEnable = 1'b1;
        mpuChipSelect  = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clock);
        tbDriveEn = 1'b0;
    endtask

    task automatic mcuRead(input logic [2:0] regIndex, output logic [7:0] value);
        @(negedge clock);
        mpuRegisterSelect = regIndex;
        tbDriveEn         = 1'b0;
        mpuChipSelect     = 1'b1;
        mpuOutputEnable   = 1'b0;
        #1 value = mpuDataBus;
        @(negedge clock);
        mpuChipSelect   = 1'b0;
        mpuOutputEnable = 1'b1;
    endtask

    task automatic readCheck(input string tag, input logic [2:0] regIndex, input logic [7:0] expected);
        logic [7:0] value;
        mcuRead(regIndex, value);
        checkOutput(tag, value, expected);
    endtask

    task automatic checkCaptured(input string tag, input int index, input logic [ADDR_W-1:0] expAddr,
                                 input logic [7:0] expData);
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
        a = (index < capAddr.size()) ? capAddr[index] : '1;
        d = (index < capData.size()) ? capData[index] : 8'hEE;
        checkOutput({tag, "Addr"}, a, expAddr);
        checkOutput({tag, "Data"}, d, expData);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        mpuChipSelect     = 1'b0;
        mpuWriteEnable    = 1'b1;
        mpuOutputEnable   = 1'b1;
        mpuRegisterSelect = 3'd0;
        tbData            = 8'h00;
        tbDriveEn         = 1'b0;
        ackManual         = 1'b0;
        autoAckEnable     = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        checkOutput("resetRequest", memoryWriteRequest, 0);
        checkOutput("resetAddress", memoryAddress, 0);
        checkOutput("resetWriteData", memoryWriteData, 0);
        readCheck("resetStatus", R_STATUS, 8'h01);
        readCheck("resetXInc", R_X_INC, 8'h01);
        readCheck("resetControl", R_CTRL, 8'h00);

        // Single pixel, manual ack, exact latency of SYNC_STAGES+3 cycles.
        applyStimulus(R_X_LOW, 8'd5);
        applyStimulus(R_X_HIGH, 8'd0);
        applyStimulus(R_Y, 8'd2);
        applyStimulus(R_DATA, 8'hAA);
        @(negedge clock);
        checkOutput("latencyEarly", memoryWriteRequest, 0);
        @(negedge clock);
        checkOutput("latencyExact", memoryWriteRequest, 1);
        checkOutput("pixelAddress", memoryAddress, 17'h00405);
        checkOutput("pixelData", memoryWriteData, 8'hAA);
        repeat (3) @(negedge clock);
        checkOutput("requestHeld", memoryWriteRequest, 1);
        checkOutput("addressHeld", memoryAddress, 17'h00405);
        ackManual = 1'b1;
        @(negedge clock);
        ackManual = 1'b0;
        @(negedge clock);
        checkOutput("requestDropped", memoryWriteRequest, 0);
        readCheck("statusIdle", R_STATUS, 8'h01);
        readCheck("cursorAfterPixel", R_X_LOW, 8'd6);

        // Wrap enabled: X=319 rolls to X=0 on the next row.
        autoAckEnable = 1'b1;
        base = capAddr.size();
        applyStimulus(R_CTRL, 8'h01);
        applyStimulus(R_X_INC, 8'd1);
        applyStimulus(R_X_LOW, 8'h3F);
        applyStimulus(R_X_HIGH, 8'h01);
        applyStimulus(R_Y, 8'd10);
        applyStimulus(R_DATA, 8'h11);
        applyStimulus(R_DATA, 8'h22);
        repeat (20) @(negedge clock);
        checkOutput("wrapCount", capAddr.size() - base, 2);
        checkCaptured("wrapFirst", base, 17'h153F, 8'h11);
        checkCaptured("wrapSecond", base + 1, 17'h1600, 8'h22);
        readCheck("wrapY", R_Y, 8'd11);
        readCheck("wrapControl", R_CTRL, 8'h01);

        // Wrap disabled: X=511 truncates to 0, Y unchanged. X_HIGH keeps only bit 0.
        base = capAddr.size();
        applyStimulus(R_CTRL, 8'h00);
        applyStimulus(R_X_LOW, 8'hFF);
        applyStimulus(R_X_HIGH, 8'hFF);
        applyStimulus(R_Y, 8'd3);
        readCheck("xHighTruncated", R_X_HIGH, 8'h01);
        applyStimulus(R_DATA, 8'h33);
        applyStimulus(R_DATA, 8'h44);
        repeat (20) @(negedge clock);
        checkCaptured("legacyFirst", base, 17'h007FF, 8'h33);
        checkCaptured("legacySecond", base + 1, 17'h00600, 8'h44);
        readCheck("legacyY", R_Y, 8'd3);

        // Stalled arbiter: one in flight, four queued, sixth dropped.
        autoAckEnable = 1'b0;
        applyStimulus(R_X_LOW, 8'd0);
        applyStimulus(R_X_HIGH, 8'd0);
        applyStimulus(R_Y, 8'd0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(R_DATA, 8'(i));
        end
        readCheck("statusOverflow", R_STATUS, 8'h0E);
        applyStimulus(R_CTRL, 8'h02);
        readCheck("statusCleared", R_STATUS, 8'h0A);
        readCheck("controlBit1NotStored", R_CTRL, 8'h00);
        base = capAddr.size();
        autoAckEnable = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("stallCount", capAddr.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            checkCaptured("stallOrder", base + i, ADDR_W'(i), 8'(i + 1));
        end
        readCheck("cursorPastDropped", R_X_LOW, 8'd6);

        // Reset while a request is pending with three entries queued.
        autoAckEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(R_DATA, 8'h70 + 8'(i));
        end
        readCheck("statusBusyQueued", R_STATUS, 8'h08);
        checkOutput("requestBeforeReset", memoryWriteRequest, 1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("requestAfterReset", memoryWriteRequest, 0);
        checkOutput("addressAfterReset", memoryAddress, 0);
        reset = 1'b0;
        readCheck("statusAfterReset", R_STATUS, 8'h01);
        readCheck("xIncAfterReset", R_X_INC, 8'h01);
        readCheck("xLowAfterReset", R_X_LOW, 8'h00);
        @(negedge clock);
        ackManual = 1'b1;
        @(negedge clock);
        ackManual = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("staleAckIgnored", memoryWriteRequest, 0);
        readCheck("statusAfterStaleAck", R_STATUS, 8'h01);

        // Bus direction: driven on reads only; a concurrent write wins.
        applyStimulus(R_X_LOW, 8'hA5);
        readCheck("readXLow", R_X_LOW, 8'hA5);
        readCheck("readStatus", R_STATUS, 8'h01);
        readCheck("readData", R_DATA, 8'h00);
        @(negedge clock);
        mpuRegisterSelect = R_X_LOW;
        tbData            = 8'h5A;
        tbDriveEn         = 1'b1;
        mpuChipSelect     = 1'b1;
        #1 checkOutput("busReleasedOeHigh", mpuDataBus, 8'h5A);
        @(negedge clock);
        mpuChipSelect = 1'b0;
        tbDriveEn     = 1'b0;
        @(negedge clock);
        mpuRegisterSelect = R_X_LOW;
        tbData            = 8'h3C;
        tbDriveEn         = 1'b1;
        mpuChipSelect     = 1'b1;
        mpuWriteEnable    = 1'b0;
        mpuOutputEnable   = 1'b0;
        #1 checkOutput("busReleasedBothStrobes", mpuDataBus, 8'h3C);
        repeat (3) @(negedge clock);
        mpuWriteEnable  = 1'b1;
        mpuOutputEnable = 1'b1;
        mpuChipSelect   = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge clock);
        tbDriveEn = 1'b0;
        readCheck("writeWinsOverRead", R_X_LOW, 8'h3C);
        applyStimulus(R_RSVD, 8'hFF);
        readCheck("reservedReadsZero", R_RSVD, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
